multdiv_iter: RTL

Parametrised iterative multiply/divide unit for the CPU execute stage. It is the width-generic successor to the fixed 32-bit multdiv. It adds:
- a signed/unsigned mode;
- a second result word (high product or remainder);
- operand latching at start;
- an explicit busy flag.

One operation runs at a time. The result is held stable until the next start.

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_signconv.sv | 14 +
 rtl/multdiv_iter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

    // The counter reaches WIDTH on the last RUN cycle, so it needs room for WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multdiv_signconv.sv
// Conditional two's-complement negation. With cin_i=1 it is a plain negate or a magnitude;
// cin_i lets the upper half of a double-width negation take the carry out of the lower half.
module multdiv_signconv #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             neg_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = (neg_i ? ~in_i : in_i) + {{(WIDTH-1){1'b0}}, neg_i & cin_i};

endmodule

// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiply / restoring divide, WIDTH cycles of iteration plus one
// sign-fix cycle and a one-cycle result-ready pulse.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic                 sgn_q, sgn_d;
    logic                 neg_q, neg_d;     // quotient/product must be negated
    logic                 sa_q, sa_d;       // dividend was negative (remainder sign)
    logic                 ovf_q, ovf_d;     // signed MOST_NEG / -1
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 exc_q, exc_d;

    logic                 start;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     acc_lo, acc_hi;
    logic [WIDTH-1:0]     lo_fix, hi_fix;
    logic                 hi_neg, hi_cin;

    assign start = ctrl_MULT | ctrl_DIV;

    multdiv_signconv #(.WIDTH(WIDTH)) u_mag_a (
        .in_i  (data_operandA),
        .neg_i (ctrl_SIGNED & data_operandA[WIDTH-1]),
        .cin_i (1'b1),
        .out_o (mag_a)
    );

    multdiv_signconv #(.WIDTH(WIDTH)) u_mag_b (
        .in_i  (data_operandB),
        .neg_i (ctrl_SIGNED & data_operandB[WIDTH-1]),
        .cin_i (1'b1),
        .out_o (mag_b)
    );

    // Multiply: accumulator is {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: accumulator is {partial remainder, dividend/quotient bits}, shifted left.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;
    assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign acc_lo = acc_q[WIDTH-1:0];
    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign hi_neg = (op_q == OP_MULT) ? neg_q : sa_q;
    assign hi_cin = (op_q == OP_MULT) ? (acc_lo == '0) : 1'b1;

    multdiv_signconv #(.WIDTH(WIDTH)) u_fix_lo (
        .in_i  (acc_lo),
        .neg_i (neg_q),
        .cin_i (1'b1),
        .out_o (lo_fix)
    );

    multdiv_signconv #(.WIDTH(WIDTH)) u_fix_hi (
        .in_i  (acc_hi),
        .neg_i (hi_neg),
        .cin_i (hi_cin),
        .out_o (hi_fix)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        exc_d   = exc_q;

        unique case (state_q)
            S_RUN: begin
                acc_d = (op_q == OP_MULT) ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                res_d   = lo_fix;
                hi_d    = hi_fix;
                if (op_q == OP_MULT) begin
                    exc_d = sgn_q ? (hi_fix != {WIDTH{lo_fix[WIDTH-1]}}) : (hi_fix != '0);
                end else if (opb_q == '0) begin
                    // With a zero divisor the remainder register ends up holding |A|,
                    // so only the quotient needs forcing.
                    res_d = '0;
                    exc_d = 1'b1;
                end else begin
                    exc_d = ovf_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        // A new start always wins, aborting whatever is in flight.
        if (start) begin
            state_d = S_RUN;
            op_d    = ctrl_MULT ? OP_MULT : OP_DIV;
            sgn_d   = ctrl_SIGNED;
            neg_d   = ctrl_SIGNED & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
            sa_d    = ctrl_SIGNED & data_operandA[WIDTH-1];
            ovf_d   = ctrl_SIGNED && (data_operandA == MOST_NEG) && (&data_operandB);
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            opb_d   = mag_b;
            cnt_d   = '0;
        end
    end

    assign data_result    = res_q;
    assign data_result_hi = hi_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q == S_RUN) || (state_q == S_FIX);

endmodule
